// File: rtl/shift_stage_ctrl.sv
// Purpose: registered issue/capture stage around the combinational barrel shifter.
//   Requests register into S1 (drives sh_*). Results with tag, zero flag and error flag land in a 2-entry FIFO.
// Latency: 2 cycles from accept to out_valid. Throughput is 1 per cycle while out_ready is held high.
// Backpressure: in_ready drops only when S1 is full and the FIFO can neither accept nor pop this cycle.
// Ports:
//   clock, reset_n        : clock and synchronous active-low reset
//   in_valid / in_ready   : request handshake, carrying in_opcode, in_data, in_shamt and in_tag
//   sh_in / sh_shiftamt / sh_left -> shifter inputs (registered); sh_out <- shifter result
//   out_valid / out_ready : result handshake, carrying out_data, out_tag, out_zero and out_err
//   busy                  : any request held in S1 or the FIFO
module shift_stage_ctrl #(
  parameter int N  = 32,
  parameter int M  = 5,
  parameter int TW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_opcode,
  input  logic [N-1:0]  in_data,
  input  logic [M-1:0]  in_shamt,
  input  logic [TW-1:0] in_tag,
  output logic [N-1:0]  sh_in,
  output logic [M-1:0]  sh_shiftamt,
  output logic          sh_left,
  input  logic [N-1:0]  sh_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [TW-1:0] out_tag,
  output logic          out_zero,
  output logic          out_err,
  output logic          busy
);

  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  // S1 issue register
  logic          r_s1_valid;
  logic [N-1:0]  r_s1_data;
  logic [M-1:0]  r_s1_shamt;
  logic          r_s1_left;
  logic [TW-1:0] r_s1_tag;
  logic          r_s1_err;

  // 2-entry result FIFO; 1-bit pointers wrap 1 -> 0 on their own
  logic [N-1:0]  r_fifo_data [2];
  logic [TW-1:0] r_fifo_tag  [2];
  logic          r_fifo_zero [2];
  logic          r_fifo_err  [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_can_push;
  logic          w_accept;
  logic          w_legal;
  logic [N-1:0]  w_push_data;

  assign out_valid   = (r_count != 2'd0);
  assign w_pop       = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still take S1.
  assign w_can_push  = (r_count < 2'd2) | w_pop;
  assign w_push      = r_s1_valid & w_can_push;
  assign in_ready    = ~r_s1_valid | w_can_push;
  assign w_accept    = in_valid & in_ready;
  assign w_legal     = (in_opcode == OP_SLL) | (in_opcode == OP_SRA);
  assign w_push_data = r_s1_err ? '0 : sh_out;

  assign sh_in       = r_s1_data;
  assign sh_shiftamt = r_s1_shamt;
  assign sh_left     = r_s1_left;

  assign out_data    = r_fifo_data[r_rd_ptr];
  assign out_tag     = r_fifo_tag[r_rd_ptr];
  assign out_zero    = r_fifo_zero[r_rd_ptr];
  assign out_err     = r_fifo_err[r_rd_ptr];
  assign busy        = r_s1_valid | (r_count != 2'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_shamt <= '0;
      r_s1_left  <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_err   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_tag[i]  <= '0;
        r_fifo_zero[i] <= 1'b0;
        r_fifo_err[i]  <= 1'b0;
      end
    end else begin
      // Accept has priority: S1 can push its old request and reload in one cycle.
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_tag   <= in_tag;
        if (w_legal) begin
          r_s1_data  <= in_data;
          r_s1_shamt <= in_shamt;
          r_s1_left  <= (in_opcode == OP_SLL);
          r_s1_err   <= 1'b0;
        end else begin
          r_s1_data  <= '0;
          r_s1_shamt <= '0;
          r_s1_left  <= 1'b0;
          r_s1_err   <= 1'b1;
        end
      end else if (w_push) begin
        r_s1_valid <= 1'b0;
      end

      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_push_data;
        r_fifo_tag[r_wr_ptr]  <= r_s1_tag;
        r_fifo_zero[r_wr_ptr] <= (w_push_data == '0);
        r_fifo_err[r_wr_ptr]  <= r_s1_err;
        r_wr_ptr              <= ~r_wr_ptr;
      end

      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_stage_ctrl.sv
module tb_shift_stage_ctrl;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        z;
    logic        e;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [3:0]  in_tag;
  logic [31:0] sh_in;
  logic [4:0]  sh_shiftamt;
  logic        sh_left;
  logic [31:0] sh_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_zero;
  logic        out_err;
  logic        busy;

  int   n_checks;
  int   n_fail;
  int   n_pops;
  logic last_acc;
  exp_t exp_q[$];
  logic [3:0] popped_tags[$];

  // Output-stability tracking across a stalled cycle.
  logic        prev_hold;
  logic [31:0] prev_data;
  logic [3:0]  prev_tag;

  shift_stage_ctrl #(.N(32), .M(5), .TW(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag),
    .sh_in(sh_in), .sh_shiftamt(sh_shiftamt), .sh_left(sh_left), .sh_out(sh_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero), .out_err(out_err), .busy(busy)
  );

  // Stand-in for the external combinational barrel shifter.
  assign sh_out = sh_left ? (sh_in << sh_shiftamt) : 32'($signed(sh_in) >>> sh_shiftamt);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: SLL is a plain left shift; SRA copies the sign bit in one position at a time.
  function automatic exp_t ref_model(input logic [4:0] op, input logic [31:0] d,
                                     input logic [4:0] s, input logic [3:0] t);
    exp_t e;
    e.t = t;
    e.e = 1'b0;
    if (op == 5'b00100) begin
      e.d = d << s;
    end else if (op == 5'b00101) begin
      e.d = d;
      for (int i = 0; i < int'(s); i++) e.d = {e.d[31], e.d[31:1]};
    end else begin
      e.d = 32'd0;
      e.e = 1'b1;
    end
    e.z = (e.d == 32'd0);
    return e;
  endfunction

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t h;
    @(negedge clock);
    last_acc = 1'b0;
    if (!reset_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_stable_data", out_data, prev_data);
        chk("stall_stable_tag", 32'(out_tag), 32'(prev_tag));
      end
      if (out_valid && out_ready) begin
        n_pops++;
        popped_tags.push_back(out_tag);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(1), 32'(0));
        end else begin
          h = exp_q.pop_front();
          chk("out_data", out_data, h.d);
          chk("out_tag", 32'(out_tag), 32'(h.t));
          chk("out_zero", 32'(out_zero), 32'(h.z));
          chk("out_err", 32'(out_err), 32'(h.e));
        end
      end
      prev_hold = out_valid & ~out_ready;
      prev_data = out_data;
      prev_tag  = out_tag;
      if (in_valid && in_ready) begin
        last_acc = 1'b1;
        exp_q.push_back(ref_model(in_opcode, in_data, in_shamt, in_tag));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] d, input logic [4:0] s,
                      input logic [3:0] t, input int bound, output int waited);
    in_valid  = 1'b1;
    in_opcode = op;
    in_data   = d;
    in_shamt  = s;
    in_tag    = t;
    waited    = 0;
    last_acc  = 1'b0;
    while (!last_acc && waited < bound) begin
      cycle();
      waited++;
    end
    chk("accepted", 32'(last_acc), 32'(1));
  endtask

  task automatic drain();
    int i;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    i = 0;
    while ((exp_q.size() != 0 || out_valid) && i < 50) begin
      cycle();
      i++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    chk("drain_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    int w;
    int pops0;
    int cyc;
    int r;
    n_checks = 0; n_fail = 0; n_pops = 0;
    prev_hold = 1'b0; last_acc = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 5'd0; in_data = 32'd0; in_shamt = 5'd0; in_tag = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_sh_in", sh_in, 32'd0);
    chk("rst_sh_shiftamt", 32'(sh_shiftamt), 32'(0));
    chk("rst_sh_left", 32'(sh_left), 32'(0));
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'(0));
    chk("rst_out_zero", 32'(out_zero), 32'(0));
    chk("rst_out_err", 32'(out_err), 32'(0));

    // Basic SLL with latency check
    out_ready = 1'b1;
    send(5'b00100, 32'h0000_0001, 5'd31, 4'd3, 2, w);
    in_valid = 1'b0;
    chk("sll_not_early", 32'(out_valid), 32'(0));
    cycle();
    chk("sll_valid", 32'(out_valid), 32'(1));
    chk("sll_data", out_data, 32'h8000_0000);
    chk("sll_tag", 32'(out_tag), 32'(3));
    chk("sll_zero", 32'(out_zero), 32'(0));
    chk("sll_err", 32'(out_err), 32'(0));
    drain();

    // Basic SRA, back-to-back
    send(5'b00101, 32'h8000_0000, 5'd4, 4'd1, 2, w);
    send(5'b00101, 32'h7FFF_FFFF, 5'd31, 4'd2, 2, w);
    in_valid = 1'b0;
    chk("sra_neg_data", out_data, 32'hF800_0000);
    cycle();
    chk("sra_pos_data", out_data, 32'h0000_0000);
    chk("sra_pos_zero", 32'(out_zero), 32'(1));
    drain();

    // Backpressure: three accepted, fourth stalls
    out_ready = 1'b0;
    popped_tags.delete();
    send(5'b00100, 32'h0000_0011, 5'd1, 4'd0, 2, w);
    send(5'b00101, 32'h8000_0022, 5'd2, 4'd1, 2, w);
    chk("bp_tag1_wait", 32'(w), 32'(1));
    send(5'b00100, 32'h0000_0033, 5'd3, 4'd2, 2, w);
    chk("bp_tag2_wait", 32'(w), 32'(1));
    in_tag = 4'd3; in_opcode = 5'b00101; in_data = 32'hF000_0044; in_shamt = 5'd8;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready_low", 32'(in_ready), 32'(0));
      chk("bp_head_tag", 32'(out_tag), 32'(0));
      chk("bp_busy", 32'(busy), 32'(1));
      cycle();
    end
    out_ready = 1'b1;
    send(5'b00101, 32'hF000_0044, 5'd8, 4'd3, 4, w);
    drain();
    chk("bp_count", 32'(popped_tags.size()), 32'(4));
    for (int i = 0; i < 4 && i < popped_tags.size(); i++)
      chk("bp_order", 32'(popped_tags[i]), 32'(i));

    // Streaming: 16 back-to-back, one result per cycle
    out_ready = 1'b1;
    pops0 = n_pops;
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      send(($urandom_range(0, 1) != 0) ? 5'b00100 : 5'b00101, $urandom,
           5'($urandom), 4'(i), 3, w);
      cyc += w;
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("stream_accept_cycles", 32'(cyc), 32'(16));
    chk("stream_results", 32'(n_pops - pops0), 32'(16));
    drain();

    // Illegal opcode followed by a legal request
    send(5'b00000, 32'hDEAD_BEEF, 5'd7, 4'd5, 2, w);
    send(5'b00100, 32'h0000_0003, 5'd2, 4'd6, 2, w);
    in_valid = 1'b0;
    chk("ill_data", out_data, 32'd0);
    chk("ill_err", 32'(out_err), 32'(1));
    chk("ill_zero", 32'(out_zero), 32'(1));
    cycle();
    chk("post_ill_data", out_data, 32'h0000_000C);
    chk("post_ill_err", 32'(out_err), 32'(0));
    drain();

    // Random traffic with random backpressure and occasional illegal opcodes
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_opcode = (r < 4) ? 5'b00100 : (r < 8) ? 5'b00101 : 5'($urandom);
      in_data   = (r == 3) ? 32'd0 : $urandom;
      in_shamt  = 5'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset mid-flight
    out_ready = 1'b0;
    send(5'b00100, 32'h1, 5'd1, 4'd7, 2, w);
    send(5'b00100, 32'h2, 5'd1, 4'd8, 2, w);
    send(5'b00100, 32'h3, 5'd1, 4'd9, 2, w);
    in_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'(1));
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b1;
    pops0 = n_pops;
    repeat (5) cycle();
    chk("mid_rst_no_stale", 32'(n_pops - pops0), 32'(0));
    send(5'b00101, 32'h8000_0000, 5'd31, 4'd4, 2, w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
